fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage ARM pipeline. Owns the PC register and drives the
//  byte address into the instruction memory (word index = addr[17:2]). Registers the returned
//  word with PC+4 into the IF/ID pipeline register for the decode stage.
//  Applies freeze (hazard stall) from hazard unit and branch redirect/flush from EXE stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset; must be word aligned
//  BUBBLE     32'h0000_0000  instruction word loaded into IF/ID on flush/reset
// PORTS
//  clk             in   1   pipeline clock, all state updates on rising edge
//  rst             in   1   synchronous, active-high reset
//  freeze          in   1   hold PC and IF/ID contents this cycle
//  branch_taken    in   1   EXE resolved taken branch; redirect PC and flush IF/ID
//  branch_addr     in   32  branch target byte address from EXE
//  inst_addr       out  32  current PC to instruction memory AddrIn (combinational = pc)
//  inst_in         in   32  instruction word from instruction memory (combinational read)
//  if_pc_out       out  32  registered PC+4 of fetched instruction
//  if_inst_out     out  32  registered instruction word
//  if_valid_out    out  1   1 = if_inst_out is a real fetched instruction, 0 = bubble
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc<=RESET_PC; if_pc_out<=0; if_inst_out<=BUBBLE; if_valid_out<=0.
//    rst overrides every other input, including mid-branch or mid-freeze.
//  - PC update priority: rst > branch_taken > freeze > increment.
//    branch_taken: pc<=branch_addr & 32'hFFFF_FFFC (bits[1:0] forced 0), freeze ignored.
//    freeze (no branch): pc holds. Otherwise pc<=pc+4, modulo 2^32 (0xFFFF_FFFC+4 -> 0).
//  - IF/ID update priority: rst > branch_taken > freeze > load.
//    branch_taken: if_inst_out<=BUBBLE, if_valid_out<=0, if_pc_out<=0 (flush; word
//      fetched this cycle is discarded).
//    freeze: all three IF/ID outputs hold value.
//    load: if_pc_out<=pc+4, if_inst_out<=inst_in, if_valid_out<=1.
//  - Latency: word at address A appears on if_inst_out one clock after inst_addr==A and
//    the edge is not frozen/flushed. Throughput one instruction per cycle with no stalls.
//  - Taken branch costs exactly one bubble from this stage: the cycle after redirect,
//    inst_addr==target; the cycle after that, target word is valid in IF/ID.
//  - Consecutive branch_taken cycles: each redirect wins; IF/ID stays flushed.
//  - freeze held N cycles: inst_addr and IF/ID stable for N cycles, then resume with no
//    lost or duplicated instruction.
//  - inst_addr is pure combinational copy of pc; no combinational path inst_in -> outputs.
//  - Addresses beyond memory depth alias in the memory; this block does not range-check.
// CONFIGURATION
//  FETCH_STATS_EN defined: adds outputs fetch_count[31:0] (+1 on every load edge, i.e.
//   if_valid_out set to 1) and flush_count[31:0] (+1 on every edge with branch_taken=1,
//   rst=0). Both reset to 0, wrap at 2^32, hold while freeze with no branch.
//  FETCH_STATS_EN undefined: those ports and counters do not exist; all other behaviour
//   identical.
// TESTING
//  1 rst=1 two edges, then release -> inst_addr=0, if_valid_out=0, if_inst_out=BUBBLE;
//    next edge if_inst_out=mem[0]=32'hE3A00014, if_pc_out=4, if_valid_out=1.
//  2 free run 5 cycles, no freeze/branch -> inst_addr 0,4,8,12,16; if_pc_out 4..20 one
//    cycle later, if_inst_out tracks mem[0..4].
//  3 freeze=1 for 3 cycles at inst_addr=8 -> inst_addr stays 8, IF/ID holds mem[1]/8;
//    release -> mem[2], if_pc_out=12 next edge; no skip, no duplicate.
//  4 branch_taken=1, branch_addr=32'h0000_0093 while freeze=1 -> next inst_addr=0x90,
//    if_valid_out=0, if_inst_out=BUBBLE; following edge loads mem[36], if_pc_out=0x94.
//  5 pc forced to 0xFFFF_FFFC via branch, then run -> inst_addr wraps to 0, if_pc_out=0.
//  6 rst asserted same edge as branch_taken and freeze -> pc=RESET_PC, outputs reset;
//    with FETCH_STATS_EN, counters 0 and 2 loads + 1 flush later read 2 and 1.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-fetch bundle: hazard/branch control in, imem bus, IF/ID register out.
// master = fetch_stage side, slave = pipeline/memory side. FETCH_STATS_EN adds counters.
interface fetch_stage_if;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] inst_addr;
    logic [31:0] inst_in;
    logic [31:0] if_pc_out;
    logic [31:0] if_inst_out;
    logic        if_valid_out;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    modport master (
        input  freeze,
        input  branch_taken,
        input  branch_addr,
        input  inst_in,
        output inst_addr,
        output if_pc_out,
        output if_inst_out,
`ifdef FETCH_STATS_EN
        output fetch_count,
        output flush_count,
`endif
        output if_valid_out
    );

    modport slave (
        output freeze,
        output branch_taken,
        output branch_addr,
        output inst_in,
        input  inst_addr,
        input  if_pc_out,
        input  if_inst_out,
`ifdef FETCH_STATS_EN
        input  fetch_count,
        input  flush_count,
`endif
        input  if_valid_out
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns PC, drives imem address, loads IF/ID with {pc+4, inst, valid}.
// Ports: clk, rst (sync, active high), bus (fetch_stage_if.master). Option: FETCH_STATS_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        load;

    assign pc_plus4      = pc + 32'd4;
    assign bus.inst_addr = pc;
    // a real fetch is captured only when neither flushed nor stalled
    assign load          = !bus.branch_taken && !bus.freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (bus.branch_taken) begin
            pc <= bus.branch_addr & 32'hFFFF_FFFC;
        end else if (!bus.freeze) begin
            pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.branch_taken) begin
            bus.if_pc_out    <= 32'h0;
            bus.if_inst_out  <= BUBBLE;
            bus.if_valid_out <= 1'b0;
        end else if (load) begin
            bus.if_pc_out    <= pc_plus4;
            bus.if_inst_out  <= bus.inst_in;
            bus.if_valid_out <= 1'b1;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fetch_count <= 32'h0;
            bus.flush_count <= 32'h0;
        end else begin
            if (load) begin
                bus.fetch_count <= bus.fetch_count + 32'd1;
            end
            if (bus.branch_taken) begin
                bus.flush_count <= bus.flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
